// File: rtl/uart_prog_loader_pkg.sv
// Shared constants for the UART program loader: sync byte, FSM encodings and
// the running-checksum helper.
package uart_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_LOAD  = 2'd1;
    localparam logic [1:0] L_CHECK = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    // Image checksum is the plain byte sum modulo 256.
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_valid
// or frame_err pulse per received frame.
import uart_prog_loader_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST_C = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r;
    logic             frame_err_r;

    // Synchronise rx and keep the previous synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame FSM: the start bit is re-checked at half a bit so short glitches are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= R_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                R_IDLE: begin
                    cnt_r <= '0;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= R_START;
                    end
                end
                R_START: begin
                    if (cnt_r == HALF_LAST_C) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        state_r   <= rx_sync_r ? R_IDLE : R_DATA;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_r == BIT_LAST_C) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= R_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_r == BIT_LAST_C) begin
                        cnt_r        <= '0;
                        byte_valid_r <= rx_sync_r;
                        frame_err_r  <= !rx_sync_r;
                        state_r      <= R_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: state_r <= R_IDLE;
            endcase
        end
    end

    assign byte_valid = byte_valid_r;
    assign rx_byte    = shift_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a checksummed SAP-1 program image from UART into the CPU RAM, holding
// the CPU in reset until the image verifies.
import uart_prog_loader_pkg::*;

module uart_prog_loader #(
    parameter int CLK_HZ       = 16000000,
    parameter int BAUD         = 115200,
    parameter int RAM_DEPTH    = 16,
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [ADDR_W:0]         LAST_IDX_C  = (ADDR_W + 1)'(RAM_DEPTH - 1);
    localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX_C = {TIMEOUT_BITS{1'b1}};

    logic                    byte_valid_s;
    logic [7:0]              rx_byte_s;
    logic                    frame_err_s;

    logic [1:0]              state_r;
    logic [ADDR_W:0]         count_r;
    logic [7:0]              sum_r;
    logic [TIMEOUT_BITS-1:0] timer_r;
    logic                    ram_we_r;
    logic [ADDR_W-1:0]       ram_addr_r;
    logic [7:0]              ram_wdata_r;
    logic                    cpu_reset_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(byte_valid_s),
        .rx_byte   (rx_byte_s),
        .frame_err (frame_err_s)
    );

    // Loader FSM: a received byte always beats a same-cycle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= L_IDLE;
            count_r     <= '0;
            sum_r       <= 8'h00;
            timer_r     <= '0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= 8'h00;
            cpu_reset_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ram_we_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                L_IDLE: begin
                    if (byte_valid_s && (rx_byte_s == SYNC_BYTE)) begin
                        cpu_reset_r <= 1'b1;
                        busy_r      <= 1'b1;
                        err_r       <= 1'b0;
                        count_r     <= '0;
                        sum_r       <= 8'h00;
                        timer_r     <= '0;
                        state_r     <= L_LOAD;
                    end
                end
                L_LOAD, L_CHECK: begin
                    if (byte_valid_s) begin
                        timer_r <= '0;
                        if (state_r == L_LOAD) begin
                            ram_we_r    <= 1'b1;
                            ram_addr_r  <= count_r[ADDR_W-1:0];
                            ram_wdata_r <= rx_byte_s;
                            sum_r       <= sum_add(sum_r, rx_byte_s);
                            count_r     <= count_r + 1'b1;
                            if (count_r == LAST_IDX_C) begin
                                state_r <= L_CHECK;
                            end
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= L_IDLE;
                            if (rx_byte_s == sum_r) begin
                                cpu_reset_r <= 1'b0;
                                done_r      <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end else if (frame_err_s || (timer_r == TIMER_MAX_C)) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= L_IDLE;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                default: state_r <= L_IDLE;
            endcase
        end
    end

    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign cpu_reset = cpu_reset_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
